// File: rtl/mod_n_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_ctr
// Description : Free-running modulo-N up-counter with terminal-count decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_ctr #(
   parameter int N     = 10,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   output logic [WIDTH-1:0] out,
   output logic             tc
);

   localparam logic [WIDTH-1:0] c_last = WIDTH'(N - 1);

   // Reject moduli that cannot be represented or that would never count.
   generate
      if ((N < 2) || (N > (2 ** WIDTH))) begin : g_param_check
         $error("mod_n_ctr: N must satisfy 2 <= N <= 2**WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_next;

   // >= rather than == lets any out-of-range code fall back to 0 in one step.
   always_comb begin
      w_count_next = r_count + 1'b1;
      if (r_count >= c_last) begin
         w_count_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign out = r_count;
   assign tc  = (r_count == c_last);

endmodule
`default_nettype wire

// File: tb/tb_mod_n_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_n_ctr
// Description : Self-checking bench for mod_n_ctr at N=10/16/2 moduli.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_n_ctr;

   logic       clk;
   logic       rstn;
   logic [3:0] out10;
   logic       tc10;
   logic [3:0] out16;
   logic       tc16;
   logic [0:0] out2;
   logic       tc2;

   int checks;
   int errors;
   // Clean rising edges sampled with rstn high since the most recent reset edge.
   int k;

   mod_n_ctr #(.N(10), .WIDTH(4)) u_dut10 (.clk(clk), .rstn(rstn), .out(out10), .tc(tc10));
   mod_n_ctr #(.N(16), .WIDTH(4)) u_dut16 (.clk(clk), .rstn(rstn), .out(out16), .tc(tc16));
   mod_n_ctr #(.N(2),  .WIDTH(1)) u_dut2  (.clk(clk), .rstn(rstn), .out(out2),  .tc(tc2));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   // Advance one rising edge, update the reference, then compare all outputs.
   task automatic step();
      @(posedge clk);
      if (rstn === 1'b0) k = 0;
      else               k = k + 1;
      #1;
      chk("out_n10", 32'(out10), 32'(k % 10));
      chk("tc_n10",  32'(tc10),  32'((k % 10) == 9));
      chk("out_n16", 32'(out16), 32'(k % 16));
      chk("tc_n16",  32'(tc16),  32'((k % 16) == 15));
      chk("out_n2",  32'(out2),  32'(k % 2));
      chk("tc_n2",   32'(tc2),   32'((k % 2) == 1));
   endtask

   task automatic set_rstn(input logic v);
      @(negedge clk);
      rstn = v;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      k      = 0;
      rstn   = 1'b0;

      // Reset hold over two edges.
      step();
      step();

      // Count and wrap through more than one full period of every modulus.
      set_rstn(1'b1);
      repeat (20) step();

      // Mid-count reset from out10 == 6.
      set_rstn(1'b0);
      step();
      set_rstn(1'b1);
      repeat (6) step();
      chk("mid_pre6", 32'(out10), 32'd6);
      set_rstn(1'b0);
      step();
      chk("mid_rst0", 32'(out10), 32'd0);
      set_rstn(1'b1);
      step();
      chk("mid_rel1", 32'(out10), 32'd1);

      // Short low pulses between edges must be ignored.
      repeat (5) begin
         #4 rstn = 1'b0;
         #5 rstn = 1'b1;
         step();
      end

      // Randomized reset pattern, with occasional between-edge glitches.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         rstn = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 7) == 0) begin
            #2 rstn = ~rstn;
            #3 rstn = ~rstn;
         end
         step();
      end

      // Long clean run so every modulus wraps several times.
      set_rstn(1'b1);
      repeat (40) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mod_n_ctr.md
Name: mod_n_ctr

Overview:
- Free-running synchronous modulo-N up-counter.
- Counts 0, 1, ..., N-1, then wraps to 0 and repeats, advancing once per rising clock edge.
- Used as a general-purpose divider/sequencer inside clocked datapaths.
- The only input besides the clock is reset. Output `tc` is optional to connect; instantiations may use only clk, rstn and out.

Parameters:
- N, 10, modulus; counter sequence length. Legal range 2 <= N <= 2^WIDTH.
- WIDTH, 4, bit width of the count output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset; one clock, synchronous, active-low.
- out  output  WIDTH  current count value, registered.
- tc  output  1  terminal-count flag, high while out == N-1 (combinational decode of the out register); may be left unconnected.

Behaviour:
- Reset: at a rising clk edge with rstn == 0, out <= 0. Reset is sampled only on clock edges; rstn changing between edges has no effect until the next edge.
- While rstn is held low, out stays 0 and tc = 0 (N >= 2).
- Count: at a rising edge with rstn == 1:
  - if out >= N-1, out <= 0;
  - otherwise out <= out + 1.
  - Using >= makes any out-of-range value recover to 0 in one cycle.
- Latency: out changes only on rising edges. The first increment (0 -> 1) occurs on the first rising edge that samples rstn == 1.
- Wrap-around: the value after N-1 is 0, with no stall or extra cycle. The period is exactly N clocks.
- tc is high for exactly one cycle per period, when out == N-1. It pulses every N cycles.
- N == 2^WIDTH: the wrap is identical to natural binary overflow; all 2^WIDTH codes are used.
- N < 2^WIDTH: codes N..2^WIDTH-1 never appear after reset.
- Reset mid-count: asserting rstn low at any count forces out to 0 on the next rising edge, taking priority over increment or wrap.
- Releasing reset resumes counting from 0.
- No enable, no load, no direction control; counting is unconditional when out of reset.
- Power-up value before the first reset edge is undefined (X in simulation). Reset must be applied for at least one rising edge.
- Parameter check: elaboration must fail if N < 2 or N > 2^WIDTH.

Test Plan:
- Reset hold: clk period 20 ns, rstn = 0 for 2 rising edges -> out = 0x0 after the first edge, stays 0x0, tc = 0.
- Count and wrap, defaults (N=10, WIDTH=4):
  - Release rstn, then run 20 edges -> out = 1,2,...,9,0,1,...,9,0.
  - tc high exactly when out == 9.
  - Period is 10 clocks.
- Mid-count reset: release reset, count to out = 6, drive rstn = 0 for one edge -> out = 0 on that edge; after release, out = 1 on the next edge.
- Asynchronous glitch ignored: pulse rstn low for 5 ns between rising edges -> count continues unaffected.
- Full-range modulus: N = 16, WIDTH = 4 -> sequence 0..15 then 0; tc high at 15.
- Minimum modulus: N = 2, WIDTH = 1 -> out toggles 0,1,0,1; tc equals out.
